// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file and exception sequencer.
// Holds STATUS (12), CAUSE (13) and EPC (14). It synchronises the external
// interrupt lines, raises int_req, and on an exception or ERET issues a
// one-cycle PC redirect to fetch.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   int_ext               : raw async interrupt lines
//   int_pending           : synchronised interrupt lines
//   cause_in              : next-CAUSE word from the cause-data logic
//   exc_req/exc_pc/exc_bd : exception take, faulting PC, delay-slot flag
//   eret                  : ERET retires
//   mtc0_we/addr/data     : CP0 write port
//   mfc0_addr/data        : CP0 read port (combinational, no bypass)
//   status_out, cause_out, epc_out, exl, int_req : register state
//   redirect_valid/pc     : one-cycle PC redirect to fetch
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_ext,
  output logic [5:0]  int_pending,
  input  logic [31:0] cause_in,
  input  logic        exc_req,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        eret,
  input  logic        mtc0_we,
  input  logic [4:0]  mtc0_addr,
  input  logic [31:0] mtc0_data,
  input  logic [4:0]  mfc0_addr,
  output logic [31:0] mfc0_data,
  output logic [31:0] status_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic        exl,
  output logic        int_req,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [31:0] STATUS_MASK = 32'h0000_FF03;
  localparam logic [4:0]  A_STATUS    = 5'd12;
  localparam logic [4:0]  A_CAUSE     = 5'd13;
  localparam logic [4:0]  A_EPC       = 5'd14;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      state, state_nxt;
  logic [31:0] status, cause, epc;
  logic [5:0]  sync1, sync2;
  logic        take_exc, take_eret, take_mtc0;
  logic [31:0] epc_exc;

  // Exception beats ERET beats MTC0; while the pipeline flushes (REDIRECT)
  // exceptions and ERET are dropped, so MTC0 can still go through.
  assign take_exc  = exc_req && (state == IDLE);
  assign take_eret = eret && !exc_req && (state == IDLE);
  assign take_mtc0 = mtc0_we && !take_exc && !take_eret;

  // Delay-slot faults restart at the branch; wraps modulo 2^32.
  assign epc_exc = exc_bd ? (exc_pc - 32'd4) : exc_pc;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:     state_nxt = (take_exc || take_eret) ? REDIRECT : IDLE;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    redirect_valid = (state == REDIRECT);
  end

  always_ff @(posedge clk) begin
    if (rst)            redirect_pc <= '0;
    else if (take_exc)  redirect_pc <= EXC_VECTOR;
    else if (take_eret) redirect_pc <= epc;   // EPC before this cycle's update
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_ext;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= '0;
      cause  <= '0;
      epc    <= '0;
    end else if (take_exc) begin
      cause     <= cause_in;
      status[1] <= 1'b1;
      // Nested exception keeps the original return address.
      if (!status[1]) epc <= epc_exc;
    end else if (take_eret) begin
      status[1] <= 1'b0;
    end else if (take_mtc0) begin
      case (mtc0_addr)
        A_STATUS: status     <= mtc0_data & STATUS_MASK;
        A_CAUSE:  cause[9:8] <= mtc0_data[9:8];
        A_EPC:    epc        <= mtc0_data;
        default:  ;
      endcase
    end
  end

  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      A_STATUS: mfc0_data = status;
      A_CAUSE:  mfc0_data = cause;
      A_EPC:    mfc0_data = epc;
      default:  mfc0_data = '0;
    endcase
  end

  assign int_pending = sync2;
  assign status_out  = status;
  assign cause_out   = cause;
  assign epc_out     = epc;
  assign exl         = status[1];
  assign int_req     = status[0] & ~status[1] & (|(status[15:10] & sync2));

endmodule
